// File: rtl/pipe_pkg.sv
// Shared encodings for the D->X pipeline: ALU operand selects, bypass selects
// and the control-field image of an X-stage bubble.
package pipe_pkg;

    localparam logic [1:0] ASEL_ZERO  = 2'b00;
    localparam logic [1:0] ASEL_PC    = 2'b10;
    localparam logic [1:0] ASEL_RS1   = 2'b11;

    localparam logic [1:0] BSEL_SHAMT = 2'b00;
    localparam logic [1:0] BSEL_RS2   = 2'b01;
    localparam logic [1:0] BSEL_IMM   = 2'b10;

    localparam logic [1:0] BYP_NONE   = 2'b00;
    localparam logic [1:0] BYP_MX     = 2'b01;
    localparam logic [1:0] BYP_WX     = 2'b10;

    typedef struct packed {
        logic       vld;
        logic       reg_we;
        logic       is_load;
        logic [1:0] asel;
        logic [1:0] bsel;
        logic [1:0] byp_rs1;
        logic [1:0] byp_rs2;
    } dx_ctrl_t;

    localparam dx_ctrl_t dx_bubble = '{
        vld:     1'b0,
        reg_we:  1'b0,
        is_load: 1'b0,
        asel:    ASEL_ZERO,
        bsel:    BSEL_SHAMT,
        byp_rs1: BYP_NONE,
        byp_rs2: BYP_NONE
    };

    // The X-stage producer is younger than M, so its result wins.
    function automatic logic [1:0] byp_select(input logic xhit, input logic mhit);
        if (xhit)
            return BYP_MX;
        else if (mhit)
            return BYP_WX;
        else
            return BYP_NONE;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational source-vs-producer compare: bypass selects for both operands
// and the load-use hazard flag for the instruction sitting in D.
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic            x_valid,
    input  logic            x_reg_we,
    input  logic            x_is_load,
    input  logic [RA_W-1:0] x_rd_addr,
    input  logic            m_reg_we,
    input  logic [RA_W-1:0] m_rd,
    input  logic            d_valid,
    input  logic [RA_W-1:0] d_rs1_addr,
    input  logic [RA_W-1:0] d_rs2_addr,
    input  logic            d_uses_rs1,
    input  logic            d_uses_rs2,
    output logic [1:0]      byp_sel_rs1,
    output logic [1:0]      byp_sel_rs2,
    output logic            luh
);

    logic xhit_1;
    logic xhit_2;
    logic mhit_1;
    logic mhit_2;

    // x0 is hardwired to zero, so a write to it never forwards.
    assign xhit_1 = x_valid & x_reg_we & (x_rd_addr != '0) & (x_rd_addr == d_rs1_addr);
    assign xhit_2 = x_valid & x_reg_we & (x_rd_addr != '0) & (x_rd_addr == d_rs2_addr);
    assign mhit_1 = m_reg_we & (m_rd != '0) & (m_rd == d_rs1_addr);
    assign mhit_2 = m_reg_we & (m_rd != '0) & (m_rd == d_rs2_addr);

    assign byp_sel_rs1 = byp_select(xhit_1, mhit_1);
    assign byp_sel_rs2 = byp_select(xhit_2, mhit_2);

    assign luh = d_valid & x_valid & x_is_load &
                 ((xhit_1 & d_uses_rs1) | (xhit_2 & d_uses_rs2));

endmodule

// File: rtl/dx_pipe_ctrl.sv
// Decode-to-execute pipeline register with operand-bypass select generation,
// load-use interlock and branch-flush bubble insertion.
module dx_pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            d_valid,
    input  logic [XLEN-1:0] d_pc,
    input  logic [RA_W-1:0] d_rs1_addr,
    input  logic [RA_W-1:0] d_rs2_addr,
    input  logic            d_uses_rs1,
    input  logic            d_uses_rs2,
    input  logic [XLEN-1:0] d_rs1_data,
    input  logic [XLEN-1:0] d_rs2_data,
    input  logic [XLEN-1:0] d_imm,
    input  logic [4:0]      d_shamt,
    input  logic [1:0]      d_asel,
    input  logic [1:0]      d_bsel,
    input  logic [RA_W-1:0] d_rd_addr,
    input  logic            d_reg_we,
    input  logic            d_is_load,
    input  logic            x_flush,
    output logic            d_stall,
    output logic            x_valid,
    output logic [XLEN-1:0] x_pc,
    output logic [XLEN-1:0] x_rs1,
    output logic [XLEN-1:0] x_rs2,
    output logic [XLEN-1:0] x_imm,
    output logic [4:0]      x_shamt,
    output logic [1:0]      x_asel,
    output logic [1:0]      x_bsel,
    output logic [RA_W-1:0] x_rd_addr,
    output logic            x_reg_we,
    output logic            x_is_load,
    output logic [1:0]      x_bypass_sel_rs1,
    output logic [1:0]      x_bypass_sel_rs2
);

    dx_ctrl_t        ctrl_p0;
    dx_ctrl_t        x_ctrl_p1;
    logic [XLEN-1:0] x_pc_p1;
    logic [XLEN-1:0] x_rs1_p1;
    logic [XLEN-1:0] x_rs2_p1;
    logic [XLEN-1:0] x_imm_p1;
    logic [4:0]      x_shamt_p1;
    logic [RA_W-1:0] x_rd_p1;
    logic [RA_W-1:0] m_rd_p2;
    logic            m_reg_we_p2;

    logic [1:0]      byp_rs1_p0;
    logic [1:0]      byp_rs2_p0;
    logic            luh_p0;
    logic            take_d_p0;

    hazard_detect #(
        .RA_W (RA_W)
    ) u_hazard (
        .x_valid     (x_ctrl_p1.vld),
        .x_reg_we    (x_ctrl_p1.reg_we),
        .x_is_load   (x_ctrl_p1.is_load),
        .x_rd_addr   (x_rd_p1),
        .m_reg_we    (m_reg_we_p2),
        .m_rd        (m_rd_p2),
        .d_valid     (d_valid),
        .d_rs1_addr  (d_rs1_addr),
        .d_rs2_addr  (d_rs2_addr),
        .d_uses_rs1  (d_uses_rs1),
        .d_uses_rs2  (d_uses_rs2),
        .byp_sel_rs1 (byp_rs1_p0),
        .byp_sel_rs2 (byp_rs2_p0),
        .luh         (luh_p0)
    );

    // A flush overrides the interlock: the D instruction is wrong-path, so
    // fetch must be free to take the redirect.
    assign d_stall   = luh_p0 & ~x_flush;
    assign take_d_p0 = ~(x_flush | luh_p0);

    // ---- D -> X boundary ----
    always_comb begin
        ctrl_p0 = dx_bubble;
        if (take_d_p0) begin
            ctrl_p0.vld     = d_valid;
            ctrl_p0.reg_we  = d_reg_we & d_valid;
            ctrl_p0.is_load = d_is_load;
            ctrl_p0.asel    = d_asel;
            ctrl_p0.bsel    = d_bsel;
            ctrl_p0.byp_rs1 = byp_rs1_p0;
            ctrl_p0.byp_rs2 = byp_rs2_p0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_ctrl_p1  <= dx_bubble;
            x_pc_p1    <= '0;
            x_rs1_p1   <= '0;
            x_rs2_p1   <= '0;
            x_imm_p1   <= '0;
            x_shamt_p1 <= '0;
            x_rd_p1    <= '0;
        end else begin
            x_ctrl_p1  <= ctrl_p0;
            x_pc_p1    <= take_d_p0 ? d_pc       : '0;
            x_rs1_p1   <= take_d_p0 ? d_rs1_data : '0;
            x_rs2_p1   <= take_d_p0 ? d_rs2_data : '0;
            x_imm_p1   <= take_d_p0 ? d_imm      : '0;
            x_shamt_p1 <= take_d_p0 ? d_shamt    : '0;
            x_rd_p1    <= take_d_p0 ? d_rd_addr  : '0;
        end
    end

    // ---- X -> M boundary (shadow of the producer one stage further on) ----
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_rd_p2     <= '0;
            m_reg_we_p2 <= 1'b0;
        end else begin
            m_rd_p2     <= x_rd_p1;
            m_reg_we_p2 <= x_ctrl_p1.reg_we & x_ctrl_p1.vld;
        end
    end

    assign x_valid          = x_ctrl_p1.vld;
    assign x_reg_we         = x_ctrl_p1.reg_we;
    assign x_is_load        = x_ctrl_p1.is_load;
    assign x_asel           = x_ctrl_p1.asel;
    assign x_bsel           = x_ctrl_p1.bsel;
    assign x_bypass_sel_rs1 = x_ctrl_p1.byp_rs1;
    assign x_bypass_sel_rs2 = x_ctrl_p1.byp_rs2;
    assign x_pc             = x_pc_p1;
    assign x_rs1            = x_rs1_p1;
    assign x_rs2            = x_rs2_p1;
    assign x_imm            = x_imm_p1;
    assign x_shamt          = x_shamt_p1;
    assign x_rd_addr        = x_rd_p1;

endmodule

// File: tb/tb_dx_pipe_ctrl.sv
// Directed, table-driven bench for dx_pipe_ctrl: a sequence of D-stage
// vectors with hand-computed stall and X-stage expectations, plus reset cases.
module tb_dx_pipe_ctrl;
    import pipe_pkg::*;

    logic        clock;
    logic        reset_n;
    logic        d_valid;
    logic [31:0] d_pc;
    logic [4:0]  d_rs1_addr;
    logic [4:0]  d_rs2_addr;
    logic        d_uses_rs1;
    logic        d_uses_rs2;
    logic [31:0] d_rs1_data;
    logic [31:0] d_rs2_data;
    logic [31:0] d_imm;
    logic [4:0]  d_shamt;
    logic [1:0]  d_asel;
    logic [1:0]  d_bsel;
    logic [4:0]  d_rd_addr;
    logic        d_reg_we;
    logic        d_is_load;
    logic        x_flush;
    logic        d_stall;
    logic        x_valid;
    logic [31:0] x_pc;
    logic [31:0] x_rs1;
    logic [31:0] x_rs2;
    logic [31:0] x_imm;
    logic [4:0]  x_shamt;
    logic [1:0]  x_asel;
    logic [1:0]  x_bsel;
    logic [4:0]  x_rd_addr;
    logic        x_reg_we;
    logic        x_is_load;
    logic [1:0]  x_bypass_sel_rs1;
    logic [1:0]  x_bypass_sel_rs2;

    int checks;
    int failures;

    dx_pipe_ctrl #(
        .XLEN (32),
        .RA_W (5)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .d_valid          (d_valid),
        .d_pc             (d_pc),
        .d_rs1_addr       (d_rs1_addr),
        .d_rs2_addr       (d_rs2_addr),
        .d_uses_rs1       (d_uses_rs1),
        .d_uses_rs2       (d_uses_rs2),
        .d_rs1_data       (d_rs1_data),
        .d_rs2_data       (d_rs2_data),
        .d_imm            (d_imm),
        .d_shamt          (d_shamt),
        .d_asel           (d_asel),
        .d_bsel           (d_bsel),
        .d_rd_addr        (d_rd_addr),
        .d_reg_we         (d_reg_we),
        .d_is_load        (d_is_load),
        .x_flush          (x_flush),
        .d_stall          (d_stall),
        .x_valid          (x_valid),
        .x_pc             (x_pc),
        .x_rs1            (x_rs1),
        .x_rs2            (x_rs2),
        .x_imm            (x_imm),
        .x_shamt          (x_shamt),
        .x_asel           (x_asel),
        .x_bsel           (x_bsel),
        .x_rd_addr        (x_rd_addr),
        .x_reg_we         (x_reg_we),
        .x_is_load        (x_is_load),
        .x_bypass_sel_rs1 (x_bypass_sel_rs1),
        .x_bypass_sel_rs2 (x_bypass_sel_rs2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic [4:0]  rd;
        logic        we;
        logic        ld;
        logic [1:0]  asel;
        logic [1:0]  bsel;
        logic        fl;
        logic        e_stall;
        logic        e_xv;
        logic        e_xwe;
        logic        e_xld;
        logic [4:0]  e_xrd;
        logic [31:0] e_xpc;
        logic [1:0]  e_xasel;
        logic [1:0]  e_xbsel;
        logic [1:0]  e_s1;
        logic [1:0]  e_s2;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(
        input logic v, input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic u1, input logic u2, input logic [4:0] rd, input logic we, input logic ld,
        input logic [1:0] asel, input logic [1:0] bsel, input logic fl,
        input logic e_stall, input logic e_xv, input logic e_xwe, input logic e_xld,
        input logic [4:0] e_xrd, input logic [31:0] e_xpc, input logic [1:0] e_xasel,
        input logic [1:0] e_xbsel, input logic [1:0] e_s1, input logic [1:0] e_s2);
        vec_t r;
        r.v = v; r.pc = pc; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2;
        r.rd = rd; r.we = we; r.ld = ld; r.asel = asel; r.bsel = bsel; r.fl = fl;
        r.e_stall = e_stall; r.e_xv = e_xv; r.e_xwe = e_xwe; r.e_xld = e_xld;
        r.e_xrd = e_xrd; r.e_xpc = e_xpc; r.e_xasel = e_xasel; r.e_xbsel = e_xbsel;
        r.e_s1 = e_s1; r.e_s2 = e_s2;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Data operands are derived from the PC so a loaded slot is recognisable.
    task automatic drive(input vec_t t);
        d_valid    = t.v;
        d_pc       = t.pc;
        d_rs1_addr = t.rs1;
        d_rs2_addr = t.rs2;
        d_uses_rs1 = t.u1;
        d_uses_rs2 = t.u2;
        d_rs1_data = t.pc ^ 32'h5a5a_0000;
        d_rs2_data = t.pc ^ 32'h0000_a5a5;
        d_imm      = t.pc + 32'd4;
        d_shamt    = t.pc[6:2];
        d_asel     = t.asel;
        d_bsel     = t.bsel;
        d_rd_addr  = t.rd;
        d_reg_we   = t.we;
        d_is_load  = t.ld;
        x_flush    = t.fl;
    endtask

    task automatic check_x(input string tag, input vec_t t);
        logic [31:0] e_rs1;
        logic [31:0] e_imm;
        logic [4:0]  e_sh;
        e_rs1 = (t.e_xpc == 32'd0) ? 32'd0 : (t.e_xpc ^ 32'h5a5a_0000);
        e_imm = (t.e_xpc == 32'd0) ? 32'd0 : (t.e_xpc + 32'd4);
        e_sh  = t.e_xpc[6:2];
        chk({tag, "_x_valid"},   {31'd0, x_valid},   {31'd0, t.e_xv});
        chk({tag, "_x_reg_we"},  {31'd0, x_reg_we},  {31'd0, t.e_xwe});
        chk({tag, "_x_is_load"}, {31'd0, x_is_load}, {31'd0, t.e_xld});
        chk({tag, "_x_rd_addr"}, {27'd0, x_rd_addr}, {27'd0, t.e_xrd});
        chk({tag, "_x_pc"},      x_pc,               t.e_xpc);
        chk({tag, "_x_rs1"},     x_rs1,              e_rs1);
        chk({tag, "_x_imm"},     x_imm,              e_imm);
        chk({tag, "_x_shamt"},   {27'd0, x_shamt},   {27'd0, e_sh});
        chk({tag, "_x_asel"},    {30'd0, x_asel},    {30'd0, t.e_xasel});
        chk({tag, "_x_bsel"},    {30'd0, x_bsel},    {30'd0, t.e_xbsel});
        chk({tag, "_sel_rs1"},   {30'd0, x_bypass_sel_rs1}, {30'd0, t.e_s1});
        chk({tag, "_sel_rs2"},   {30'd0, x_bypass_sel_rs2}, {30'd0, t.e_s2});
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_x_valid"},  {31'd0, x_valid},  32'd0);
        chk({tag, "_x_reg_we"}, {31'd0, x_reg_we}, 32'd0);
        chk({tag, "_x_is_load"},{31'd0, x_is_load},32'd0);
        chk({tag, "_x_rd_addr"},{27'd0, x_rd_addr},32'd0);
        chk({tag, "_x_pc"},     x_pc,              32'd0);
        chk({tag, "_x_rs1"},    x_rs1,             32'd0);
        chk({tag, "_x_rs2"},    x_rs2,             32'd0);
        chk({tag, "_x_imm"},    x_imm,             32'd0);
        chk({tag, "_x_asel"},   {30'd0, x_asel},   32'd0);
        chk({tag, "_x_bsel"},   {30'd0, x_bsel},   32'd0);
        chk({tag, "_sel_rs1"},  {30'd0, x_bypass_sel_rs1}, 32'd0);
        chk({tag, "_sel_rs2"},  {30'd0, x_bypass_sel_rs2}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t t;
        checks   = 0;
        failures = 0;

        //            v  pc        rs1    rs2    u1 u2 rd     we ld asel  bsel  fl | st xv xwe xld xrd    xpc       xasel xbsel s1     s2
        vecs[0]  = mk(1, 32'h100, 5'd1,  5'd2,  1, 1, 5'd5,  1, 0, 2'b11, 2'b01, 0,  0, 1, 1, 0, 5'd5,  32'h100, 2'b11, 2'b01, 2'b00, 2'b00);
        vecs[1]  = mk(1, 32'h104, 5'd5,  5'd3,  1, 1, 5'd6,  1, 0, 2'b11, 2'b01, 0,  0, 1, 1, 0, 5'd6,  32'h104, 2'b11, 2'b01, 2'b01, 2'b00);
        vecs[2]  = mk(1, 32'h108, 5'd1,  5'd5,  1, 1, 5'd8,  1, 0, 2'b11, 2'b01, 0,  0, 1, 1, 0, 5'd8,  32'h108, 2'b11, 2'b01, 2'b00, 2'b10);
        vecs[3]  = mk(1, 32'h10c, 5'd0,  5'd0,  0, 0, 5'd5,  1, 0, 2'b10, 2'b10, 0,  0, 1, 1, 0, 5'd5,  32'h10c, 2'b10, 2'b10, 2'b00, 2'b00);
        vecs[4]  = mk(1, 32'h110, 5'd9,  5'd9,  1, 1, 5'd5,  1, 0, 2'b11, 2'b10, 0,  0, 1, 1, 0, 5'd5,  32'h110, 2'b11, 2'b10, 2'b00, 2'b00);
        vecs[5]  = mk(1, 32'h114, 5'd5,  5'd5,  1, 1, 5'd10, 1, 0, 2'b11, 2'b01, 0,  0, 1, 1, 0, 5'd10, 32'h114, 2'b11, 2'b01, 2'b01, 2'b01);
        vecs[6]  = mk(1, 32'h118, 5'd2,  5'd0,  1, 0, 5'd7,  1, 1, 2'b11, 2'b10, 0,  0, 1, 1, 1, 5'd7,  32'h118, 2'b11, 2'b10, 2'b00, 2'b00);
        vecs[7]  = mk(1, 32'h11c, 5'd7,  5'd1,  1, 1, 5'd11, 1, 0, 2'b11, 2'b01, 0,  1, 0, 0, 0, 5'd0,  32'h0,   2'b00, 2'b00, 2'b00, 2'b00);
        vecs[8]  = mk(1, 32'h11c, 5'd7,  5'd1,  1, 1, 5'd11, 1, 0, 2'b11, 2'b01, 0,  0, 1, 1, 0, 5'd11, 32'h11c, 2'b11, 2'b01, 2'b10, 2'b00);
        vecs[9]  = mk(1, 32'h120, 5'd3,  5'd4,  1, 1, 5'd0,  1, 1, 2'b11, 2'b10, 0,  0, 1, 1, 1, 5'd0,  32'h120, 2'b11, 2'b10, 2'b00, 2'b00);
        vecs[10] = mk(1, 32'h124, 5'd0,  5'd0,  1, 1, 5'd0,  1, 1, 2'b11, 2'b10, 0,  0, 1, 1, 1, 5'd0,  32'h124, 2'b11, 2'b10, 2'b00, 2'b00);
        vecs[11] = mk(1, 32'h128, 5'd0,  5'd0,  1, 1, 5'd12, 1, 0, 2'b11, 2'b01, 0,  0, 1, 1, 0, 5'd12, 32'h128, 2'b11, 2'b01, 2'b00, 2'b00);
        vecs[12] = mk(1, 32'h12c, 5'd1,  5'd0,  1, 0, 5'd7,  1, 1, 2'b11, 2'b10, 0,  0, 1, 1, 1, 5'd7,  32'h12c, 2'b11, 2'b10, 2'b00, 2'b00);
        vecs[13] = mk(1, 32'h130, 5'd7,  5'd2,  1, 1, 5'd13, 1, 0, 2'b11, 2'b01, 1,  0, 0, 0, 0, 5'd0,  32'h0,   2'b00, 2'b00, 2'b00, 2'b00);
        vecs[14] = mk(0, 32'h134, 5'd7,  5'd2,  1, 1, 5'd14, 1, 0, 2'b10, 2'b10, 0,  0, 0, 0, 0, 5'd14, 32'h134, 2'b10, 2'b10, 2'b10, 2'b00);
        vecs[15] = mk(1, 32'h138, 5'd14, 5'd7,  1, 1, 5'd15, 1, 0, 2'b11, 2'b01, 0,  0, 1, 1, 0, 5'd15, 32'h138, 2'b11, 2'b01, 2'b00, 2'b00);

        // Power-on reset with idle D inputs.
        t = mk(0, 32'h0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, ASEL_ZERO, BSEL_SHAMT, 0,
               0, 0, 0, 0, 5'd0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00);
        drive(t);
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("por");
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d_d_stall", i), {31'd0, d_stall}, {31'd0, vecs[i].e_stall});
            @(posedge clock);
            #1;
            check_x($sformatf("v%0d", i), vecs[i]);
        end

        // Asynchronous reset mid-cycle while X holds a valid instruction.
        chk("pre_rst_x_valid", {31'd0, x_valid}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");

        // First edge after release loads D; rs1=15 was the pre-reset producer
        // but the shadow slot is cleared, so no bypass.
        @(negedge clock);
        t = mk(1, 32'h13c, 5'd15, 5'd0, 1, 0, 5'd16, 1, 0, ASEL_RS1, BSEL_IMM, 0,
               0, 1, 1, 0, 5'd16, 32'h13c, ASEL_RS1, BSEL_IMM, BYP_NONE, BYP_NONE);
        drive(t);
        #1;
        reset_n = 1'b1;
        chk("rel_d_stall", {31'd0, d_stall}, 32'd0);
        @(posedge clock);
        #1;
        check_x("rel", t);

        // A load-use against a load just released from reset still interlocks.
        @(negedge clock);
        t = mk(1, 32'h140, 5'd16, 5'd0, 1, 0, 5'd17, 1, 1, ASEL_PC, BSEL_IMM, 0,
               0, 1, 1, 1, 5'd17, 32'h140, ASEL_PC, BSEL_IMM, BYP_MX, BYP_NONE);
        drive(t);
        #1;
        chk("post_d_stall", {31'd0, d_stall}, 32'd0);
        @(posedge clock);
        #1;
        check_x("post", t);
        @(negedge clock);
        t = mk(1, 32'h144, 5'd1, 5'd17, 0, 1, 5'd18, 1, 0, ASEL_RS1, BSEL_RS2, 0,
               1, 0, 0, 0, 5'd0, 32'h0, ASEL_ZERO, BSEL_SHAMT, BYP_NONE, BYP_NONE);
        drive(t);
        #1;
        chk("luh2_d_stall", {31'd0, d_stall}, 32'd1);
        @(posedge clock);
        #1;
        check_x("luh2", t);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dx_pipe_ctrl.md
Name: dx_pipe_ctrl

Overview:
- Decode-to-execute pipeline register, forwarding-select generator and load-use interlock in one block.
- Captures decoded operands and control from the D stage.
- Computes the operand-bypass selects that the X-stage ALU operand mux consumes one cycle later.
- Stalls D and inserts bubbles on load-use hazards and branch flushes. Sits between the decoder/register file and the ALU operand mux.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register address width

Ports:
clock  in  1  single rising-edge clock
reset_n  in  1  reset, asynchronous, active-low
d_valid  in  1  D slot holds a real instruction
d_pc  in  XLEN  PC of D instruction
d_rs1_addr  in  RA_W  source 1 index
d_rs2_addr  in  RA_W  source 2 index
d_uses_rs1  in  1  instruction reads rs1
d_uses_rs2  in  1  instruction reads rs2
d_rs1_data  in  XLEN  register-file read 1
d_rs2_data  in  XLEN  register-file read 2
d_imm  in  XLEN  decoded immediate
d_shamt  in  5  shift amount
d_asel  in  2  ALU A select (10 pc, 11 rs1, 00 zero)
d_bsel  in  2  ALU B select (00 shamt, 01 rs2, 10 imm)
d_rd_addr  in  RA_W  destination index
d_reg_we  in  1  instruction writes rd
d_is_load  in  1  instruction is a load
x_flush  in  1  branch/jump redirect resolved in X this cycle
d_stall  out  1  hold fetch/decode registers (combinational)
x_valid, x_pc, x_rs1, x_rs2, x_imm, x_shamt, x_asel, x_bsel, x_rd_addr, x_reg_we, x_is_load  out  (widths as D)  registered X-stage fields
x_bypass_sel_rs1  out  2  00 none, 01 MX, 10 WX
x_bypass_sel_rs2  out  2  same encoding

Behaviour:
- Reset (async, reset_n=0):
  - All x_* outputs are 0, including x_valid, x_asel=00, x_bsel=00 and both bypass selects=00.
  - Internal M shadow slot (m_rd, m_reg_we) is 0.
- Downstream never back-pressures; X and M advance every cycle.
- Internal M shadow slot: each clock, m_rd<=x_rd_addr and m_reg_we<=x_reg_we&x_valid.
- Register file is write-through: the W-stage write is visible on d_rs*_data in the same cycle. Forwarding therefore covers only two producers.
- Hit definitions, evaluated on current D versus current X and M:
  - xhit_k = x_valid & x_reg_we & (x_rd_addr!=0) & (x_rd_addr==d_rsk_addr).
  - mhit_k = m_reg_we & (m_rd!=0) & (m_rd==d_rsk_addr).
- Bypass select captured at the edge: 01 if xhit_k, else 10 if mhit_k, else 00. MX has priority because it is the youngest producer.
- Load-use hazard:
  - luh = d_valid & x_valid & x_is_load & ((xhit_1&d_uses_rs1)|(xhit_2&d_uses_rs2)).
  - d_stall = luh & ~x_flush.
- Next X state, in priority order:
  1. x_flush=1: load bubble. D instruction is wrong-path; d_stall=0 so fetch takes the redirect.
  2. luh=1: load bubble; D holds. Next cycle the load is in M, the dependency resolves as mhit, select 10, no further stall.
  3. Otherwise: load all D fields; x_valid<=d_valid.
- Bubble: x_valid=0, x_reg_we=0, x_is_load=0, x_rd_addr=0, x_asel=00, x_bsel=00, bypass selects=00, data fields=0.
- D fields with d_valid=0 load normally, but x_reg_we<=d_reg_we&d_valid.
- Latency: one cycle from D inputs to x_* outputs.
- Reset deasserted mid-stream: first edge after release loads D normally. No bypass hit is possible since the shadow slot is 0.

Decomposition:
- Shared package pipe_pkg holds:
  - ASEL_ZERO/ASEL_PC/ASEL_RS1 and BSEL_SHAMT/BSEL_RS2/BSEL_IMM constants.
  - BYP_NONE=00, BYP_MX=01, BYP_WX=10.
  - A dx_bubble constant for all bubble field values.
- One combinational sub-module, hazard_detect: computes xhit/mhit/bypass selects/luh from addresses and slot state. Instantiated once; also reusable by the branch comparator.

Test Plan:
1. reset_n pulsed low mid-stream with x_valid=1 -> all x_* and selects read 0 immediately (asynchronously), x_valid=0.
2. Back-to-back dependency: add rd=5 in X, D reads rs1=5 (asel=11) -> next cycle x_bypass_sel_rs1=01, d_stall=0.
3. Distance-two plus priority:
   - rd=5 in M only, D reads rs2=5 (bsel=01) -> sel_rs2=10.
   - rd=5 in both X and M -> sel=01.
4. Load-use: lw rd=7 in X, D uses rs1=7 -> d_stall=1 for exactly one cycle, then x_valid=0 bubble; next cycle D enters X with sel_rs1=10.
5. rd=0: producer writing x0 in X and M, D reads rs1=0 -> sel_rs1=00, no stall even if producer is a load.
6. x_flush=1 with a simultaneous load-use -> d_stall=0, next cycle x_valid=0, x_reg_we=0, selects 00.
